// File: rtl/quad_gen_mmio_pkg.sv
// quad_gen_mmio_pkg
//   Shared definitions for the quadrature generator: register offsets,
//   CTRL/STATUS bit positions, FSM state encoding and the forward phase
//   order (the same order encoder_mmio decodes as forward motion).
package quad_gen_mmio_pkg;

  localparam logic [4:0] REG_CTRL     = 5'h00;
  localparam logic [4:0] REG_STATUS   = 5'h04;
  localparam logic [4:0] REG_STEPS    = 5'h08;
  localparam logic [4:0] REG_PERIOD   = 5'h0C;
  localparam logic [4:0] REG_POSITION = 5'h10;
  localparam logic [4:0] REG_REMAIN   = 5'h14;

  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_DIR     = 1;
  localparam int CTRL_START   = 2;
  localparam int CTRL_ABORT   = 3;
  localparam int CTRL_CLR_POS = 4;
  localparam int CTRL_IRQ_EN  = 5;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Forward order {a,b}: 00 -> 01 -> 11 -> 10 -> 00
  localparam logic [1:0] PH_0 = 2'b00;
  localparam logic [1:0] PH_1 = 2'b01;
  localparam logic [1:0] PH_2 = 2'b11;
  localparam logic [1:0] PH_3 = 2'b10;

  function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic fwd);
    logic [1:0] nxt;
    nxt = PH_0;
    case (ph)
      PH_0:    nxt = fwd ? PH_1 : PH_3;
      PH_1:    nxt = fwd ? PH_2 : PH_0;
      PH_2:    nxt = fwd ? PH_3 : PH_1;
      default: nxt = fwd ? PH_0 : PH_2;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_gen_mmio_if.sv
// quad_gen_mmio_if
//   Simple peripheral bus shared by the MMIO blocks.
//   bus_addr  : register byte address
//   bus_we    : write strobe, sampled on posedge clk
//   bus_re    : read strobe, sampled on posedge clk
//   bus_wdata : write data
//   bus_rdata : registered read data (1-cycle latency)
interface quad_gen_mmio_if;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic        bus_re;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (
    output bus_addr, bus_we, bus_re, bus_wdata,
    input  bus_rdata
  );

  modport slave (
    input  bus_addr, bus_we, bus_re, bus_wdata,
    output bus_rdata
  );
endinterface

// File: rtl/quad_phase_seq.sv
// quad_phase_seq
//   Two-bit quadrature phase register. Each cycle with step=1 moves the
//   phase one edge forward (dir=1) or backward (dir=0). Outputs come
//   straight from the flops so they never glitch.
//   clk, reset : clock, asynchronous active-high reset (phase -> 00)
//   step       : advance one edge this cycle
//   dir        : 1 = forward, 0 = reverse
//   enc_a/enc_b: quadrature outputs
module quad_phase_seq
  import quad_gen_mmio_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic step,
  input  logic dir,
  output logic enc_a,
  output logic enc_b
);

  logic [1:0] phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= PH_0;
    end else if (step) begin
      phase <= next_phase(phase, dir);
    end
  end

  assign enc_a = phase[1];
  assign enc_b = phase[0];

endmodule

// File: rtl/quad_gen_mmio.sv
// quad_gen_mmio
//   Memory-mapped quadrature generator. Emits a programmed number of
//   enc_a/enc_b edges, one every max(PERIOD,1) clocks, in the programmed
//   direction, and tracks the signed net position.
//   clk   : system clock
//   reset : asynchronous, active-high; clears every register and output
//   bus   : register bus (slave side), 1-cycle registered reads
//   enc_a, enc_b : quadrature outputs
//   irq   : DONE & IRQ_EN (level)
module quad_gen_mmio
  import quad_gen_mmio_pkg::*;
#(
  parameter int          PERIOD_W  = 16,
  parameter logic [31:0] ADDR_BASE = 32'h0
) (
  input  logic             clk,
  input  logic             reset,
  quad_gen_mmio_if.slave   bus,
  output logic             enc_a,
  output logic             enc_b,
  output logic             irq
);

  state_t                state;
  logic                  ctrl_enable;
  logic                  ctrl_dir;
  logic                  ctrl_irq_en;
  logic                  done;
  logic [31:0]           steps;
  logic [PERIOD_W-1:0]   period;
  logic signed [31:0]    position;
  logic [31:0]           remain;
  logic [PERIOD_W-1:0]   div;
  logic [31:0]           rd_mux;

  logic                  hit;
  logic [4:0]            reg_off;
  logic                  wr_ctrl, wr_steps, wr_period;
  logic                  busy;
  logic                  start_acc, run_go, zero_done;
  logic                  stop, div_hit, edge_step, clr_pos;
  logic [PERIOD_W-1:0]   eff_period;

  // Base match ignores the low 5 bits, which select the register.
  assign hit     = (bus.bus_addr[31:5] == ADDR_BASE[31:5]);
  assign reg_off = bus.bus_addr[4:0];

  assign wr_ctrl   = bus.bus_we & hit & (reg_off == REG_CTRL);
  assign wr_steps  = bus.bus_we & hit & (reg_off == REG_STEPS);
  assign wr_period = bus.bus_we & hit & (reg_off == REG_PERIOD);

  assign busy = (state == ST_RUN);

  // START qualifies on the ENABLE bit written in the same CTRL write.
  assign start_acc = wr_ctrl & bus.bus_wdata[CTRL_START] & bus.bus_wdata[CTRL_ENABLE] & ~busy;
  assign run_go    = start_acc & (steps != 32'd0);
  assign zero_done = start_acc & (steps == 32'd0);

  // Abort / disable takes precedence over an edge due in the same cycle.
  assign stop      = busy & wr_ctrl & (bus.bus_wdata[CTRL_ABORT] | ~bus.bus_wdata[CTRL_ENABLE]);
  assign div_hit   = busy & (div == PERIOD_W'(1));
  assign edge_step = div_hit & ~stop;
  assign clr_pos   = wr_ctrl & bus.bus_wdata[CTRL_CLR_POS];

  // PERIOD=0 runs at the same rate as PERIOD=1.
  assign eff_period = (period == '0) ? PERIOD_W'(1) : period;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      ctrl_enable <= 1'b0;
      ctrl_dir    <= 1'b0;
      ctrl_irq_en <= 1'b0;
      done        <= 1'b0;
      steps       <= '0;
      period      <= '0;
      position    <= '0;
      remain      <= '0;
      div         <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_enable <= bus.bus_wdata[CTRL_ENABLE];
        ctrl_irq_en <= bus.bus_wdata[CTRL_IRQ_EN];
        if (!busy) ctrl_dir <= bus.bus_wdata[CTRL_DIR];
      end
      if (wr_steps && !busy)  steps  <= bus.bus_wdata;
      if (wr_period && !busy) period <= bus.bus_wdata[PERIOD_W-1:0];

      case (state)
        ST_IDLE: begin
          if (run_go) begin
            state  <= ST_RUN;
            remain <= steps;
            div    <= eff_period;
            done   <= 1'b0;
          end else if (zero_done) begin
            done <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_IDLE;
          end else if (div_hit) begin
            div    <= eff_period;
            remain <= remain - 32'd1;
            if (remain == 32'd1) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end
          end else begin
            div <= div - PERIOD_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A clear coinciding with an edge wins.
      if (clr_pos) begin
        position <= '0;
      end else if (edge_step) begin
        position <= ctrl_dir ? position + 32'sd1 : position - 32'sd1;
      end
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    if (hit) begin
      case (reg_off)
        REG_CTRL:     rd_mux = {26'd0, ctrl_irq_en, 3'd0, ctrl_dir, ctrl_enable};
        REG_STATUS:   rd_mux = {30'd0, done, busy};
        REG_STEPS:    rd_mux = steps;
        REG_PERIOD:   rd_mux = 32'(period);
        REG_POSITION: rd_mux = position;
        REG_REMAIN:   rd_mux = remain;
        default:      rd_mux = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.bus_rdata <= '0;
    end else if (bus.bus_re) begin
      bus.bus_rdata <= rd_mux;
    end
  end

  assign irq = done & ctrl_irq_en;

  quad_phase_seq u_phase (
    .clk   (clk),
    .reset (reset),
    .step  (edge_step),
    .dir   (ctrl_dir),
    .enc_a (enc_a),
    .enc_b (enc_b)
  );

endmodule

// File: tb/tb_quad_gen_mmio.sv
// tb_quad_gen_mmio
//   Directed bench for quad_gen_mmio: a table of complete runs with
//   hand-computed results, followed by hand-written sequences for abort,
//   zero-length start, clear-on-edge, busy-write lockout, irq and
//   asynchronous reset.
module tb_quad_gen_mmio;

  localparam logic [31:0] A_CTRL     = 32'h00;
  localparam logic [31:0] A_STATUS   = 32'h04;
  localparam logic [31:0] A_STEPS    = 32'h08;
  localparam logic [31:0] A_PERIOD   = 32'h0C;
  localparam logic [31:0] A_POSITION = 32'h10;
  localparam logic [31:0] A_REMAIN   = 32'h14;

  typedef struct {
    logic        dir;
    int          steps;
    int          period;
    logic [1:0]  exp_first;
    logic [1:0]  exp_final;
    logic [31:0] exp_pos;
  } run_vec_t;

  logic clk = 1'b0;
  logic reset;
  logic enc_a, enc_b, irq;

  quad_gen_mmio_if bus_if ();

  quad_gen_mmio #(
    .PERIOD_W  (16),
    .ADDR_BASE (32'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .enc_a (enc_a),
    .enc_b (enc_b),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int edges  = 0;
  logic [1:0] last_ph = 2'b00;
  run_vec_t runs [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // One clock; sample 1ns after the edge and count phase changes.
  task automatic tick();
    @(posedge clk);
    #1;
    if ({enc_a, enc_b} !== last_ph) edges++;
    last_ph = {enc_a, enc_b};
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.bus_addr  = a;
    bus_if.bus_wdata = d;
    bus_if.bus_we    = 1'b1;
    tick();
    bus_if.bus_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_if.bus_addr = a;
    bus_if.bus_re   = 1'b1;
    tick();
    bus_if.bus_re   = 1'b0;
    d = bus_if.bus_rdata;
  endtask

  task automatic check_reg(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    chk(nm, d, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int c;
    int last_c;
    int prev;
    int spacing_err;
    int eff;
    logic got;

    // dir, steps, period, first phase, final phase, cumulative position
    runs[0] = '{1'b1, 20, 4, 2'b01, 2'b00, 32'h0000_0014};
    runs[1] = '{1'b0,  8, 4, 2'b10, 2'b00, 32'h0000_000C};
    runs[2] = '{1'b1,  3, 0, 2'b01, 2'b10, 32'h0000_000F};
    runs[3] = '{1'b0,  5, 2, 2'b11, 2'b11, 32'h0000_000A};

    bus_if.bus_addr  = 32'd0;
    bus_if.bus_wdata = 32'd0;
    bus_if.bus_we    = 1'b0;
    bus_if.bus_re    = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    chk("reset_enc", 32'({enc_a, enc_b}), 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);
    chk("reset_rdata", bus_if.bus_rdata, 32'd0);
    check_reg("reset_status", A_STATUS, 32'd0);
    check_reg("reset_position", A_POSITION, 32'd0);
    check_reg("reset_remain", A_REMAIN, 32'd0);

    for (int i = 0; i < 4; i++) begin
      eff = (runs[i].period == 0) ? 1 : runs[i].period;
      bus_write(A_PERIOD, 32'(runs[i].period));
      bus_write(A_STEPS, 32'(runs[i].steps));
      base = edges;
      prev = edges;
      c = 0;
      last_c = 0;
      spacing_err = 0;
      bus_write(A_CTRL, 32'h5 | {30'd0, runs[i].dir, 1'b0});
      for (int k = 0; k < runs[i].steps * eff + 4; k++) begin
        tick();
        c++;
        if (edges != prev) begin
          if (edges - base == 1) begin
            chk($sformatf("run%0d_first_latency", i), 32'(c), 32'(eff));
            chk($sformatf("run%0d_first_phase", i), 32'({enc_a, enc_b}), 32'(runs[i].exp_first));
          end else if (c - last_c != eff) begin
            spacing_err++;
          end
          last_c = c;
          prev = edges;
        end
      end
      chk($sformatf("run%0d_spacing_errors", i), 32'(spacing_err), 32'd0);
      chk($sformatf("run%0d_edges", i), 32'(edges - base), 32'(runs[i].steps));
      chk($sformatf("run%0d_final_phase", i), 32'({enc_a, enc_b}), 32'(runs[i].exp_final));
      check_reg($sformatf("run%0d_status", i), A_STATUS, 32'h2);
      check_reg($sformatf("run%0d_position", i), A_POSITION, runs[i].exp_pos);
      check_reg($sformatf("run%0d_remain", i), A_REMAIN, 32'd0);
    end

    // Abort 35 clocks into a PERIOD=10 run: edges at +10, +20, +30 only.
    bus_write(A_PERIOD, 32'd10);
    bus_write(A_STEPS, 32'd100);
    base = edges;
    bus_write(A_CTRL, 32'h07);
    repeat (34) tick();
    bus_write(A_CTRL, 32'h09);
    repeat (30) tick();
    chk("abort_edges", 32'(edges - base), 32'd3);
    chk("abort_phase_frozen", 32'({enc_a, enc_b}), 32'h1);
    check_reg("abort_status", A_STATUS, 32'd0);
    check_reg("abort_remain", A_REMAIN, 32'd97);
    check_reg("abort_position", A_POSITION, 32'd13);

    // Start with STEPS=0: immediate DONE, no edges.
    bus_write(A_STEPS, 32'd0);
    base = edges;
    bus_write(A_CTRL, 32'h07);
    repeat (10) tick();
    check_reg("zero_status", A_STATUS, 32'h2);
    chk("zero_edges", 32'(edges - base), 32'd0);

    // CLR_POS on the cycle of the second edge, then a STEPS write while busy.
    bus_write(A_PERIOD, 32'd4);
    bus_write(A_STEPS, 32'd4);
    base = edges;
    bus_write(A_CTRL, 32'h07);
    repeat (7) tick();
    bus_write(A_CTRL, 32'h13);
    bus_write(A_STEPS, 32'd50);
    repeat (12) tick();
    chk("clr_edges", 32'(edges - base), 32'd4);
    check_reg("clr_position", A_POSITION, 32'd2);
    check_reg("busy_steps_readback", A_STEPS, 32'd4);
    check_reg("clr_status", A_STATUS, 32'h2);

    // irq follows DONE once IRQ_EN is set; a new START drops it.
    chk("irq_disabled", 32'(irq), 32'd0);
    bus_write(A_CTRL, 32'h27);
    chk("irq_after_start", 32'(irq), 32'd0);
    base = edges;
    got = 1'b0;
    for (int k = 0; k < 24; k++) begin
      tick();
      if (edges - base == 3 && !got) chk("irq_before_last_edge", 32'(irq), 32'd0);
      if (edges - base == 4 && !got) begin
        got = 1'b1;
        chk("irq_with_done", 32'(irq), 32'd1);
      end
    end
    chk("irq_run_edges", 32'(edges - base), 32'd4);
    chk("irq_held", 32'(irq), 32'd1);
    bus_write(A_CTRL, 32'h27);
    chk("irq_dropped_by_start", 32'(irq), 32'd0);

    // Reset mid-run while the phase is 11.
    base = edges;
    for (int k = 0; k < 10 && edges == base; k++) tick();
    chk("prereset_phase", 32'({enc_a, enc_b}), 32'h3);
    check_reg("prereset_rdata", A_STEPS, 32'd4);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_enc", 32'({enc_a, enc_b}), 32'd0);
    chk("async_reset_rdata", bus_if.bus_rdata, 32'd0);
    chk("async_reset_irq", 32'(irq), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/quad_gen_mmio.md
Name: quad_gen_mmio

Overview:
- Memory-mapped quadrature signal generator: emits enc_a/enc_b waveforms for a programmed number of edges, at a programmed rate and direction.
- It is the transmit-side counterpart of encoder_mmio and drives that block's enc_a/enc_b inputs in loopback tests and motor-emulation setups.
- It uses the same simple bus (bus_addr/bus_we/bus_re/bus_wdata/bus_rdata) as the other peripherals.

Parameters:
- PERIOD_W, 16, width of the PERIOD register (clocks per quadrature edge).
- ADDR_BASE, 32'h0, base address; registers decode on bus_addr[4:0] after matching the base.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- bus_addr  in  32  register byte address
- bus_we  in  1  write strobe, sampled on posedge clk
- bus_re  in  1  read strobe, sampled on posedge clk
- bus_wdata  in  32  write data
- bus_rdata  out  32  registered read data
- enc_a  out  1  quadrature channel A
- enc_b  out  1  quadrature channel B
- irq  out  1  done interrupt, level (done & IRQ_EN)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. All outputs and registers are 0 on reset: enc_a=0, enc_b=0, bus_rdata=0, irq=0, state IDLE.
- Register map:
  - 0x00 CTRL: [0] ENABLE, [1] DIR (1=fwd), [2] START (self-clearing pulse), [3] ABORT (pulse), [4] CLR_POS (pulse), [5] IRQ_EN.
  - 0x04 STATUS (RO): [0] BUSY, [1] DONE (sticky).
  - 0x08 STEPS: 32-bit edge count.
  - 0x0C PERIOD: PERIOD_W bits.
  - 0x10 POSITION (RO): signed 32-bit net edges emitted.
  - 0x14 REMAIN (RO): edges still to emit.
- Reads: on a posedge with bus_re=1, bus_rdata <= register[addr]. Latency is 1 cycle. The value holds while bus_re=0. Unmapped addresses read 0.
- Writes: take effect on the posedge with bus_we=1. Writes to unmapped or RO addresses are ignored. STEPS, PERIOD, and the DIR bit are ignored while BUSY. ENABLE, ABORT, CLR_POS and IRQ_EN are always accepted.
- Phase sequence, forward: {a,b} 00->01->11->10->00. Reverse is the opposite order. One step = one edge. Phase persists across runs and aborts and is never reset except by reset.
- FSM states: IDLE, RUN.
  - IDLE -> RUN: START=1 & ENABLE=1 & STEPS!=0. Load REMAIN=STEPS, load the divider with max(PERIOD,1), clear DONE. BUSY=1 from the next cycle.
  - START=1 & ENABLE=1 & STEPS==0: set DONE, stay in IDLE, emit no edges.
  - START while BUSY or while ENABLE=0: ignored.
  - RUN: the divider counts down each clock. When it reaches 0, advance the phase one step, REMAIN -= 1, POSITION += 1 (fwd) or -= 1 (rev), and reload the divider.
  - First edge: PERIOD cycles after the START write cycle. Edge spacing: exactly max(PERIOD,1) clocks. PERIOD=0 behaves as 1.
  - RUN -> IDLE when the final edge is emitted (REMAIN becomes 0): DONE=1 in the same cycle as that edge, BUSY=0 the next cycle.
  - RUN -> IDLE on ABORT=1 or ENABLE cleared: no further edges, outputs hold the current phase, DONE stays 0, REMAIN keeps its residual value.
- DONE is cleared by an accepted START or by reset only.
- CLR_POS sets POSITION to 0. If it coincides with an edge, the clear wins (POSITION=0 that cycle).
- POSITION wraps in two's complement at ±2^31.
- irq = DONE & IRQ_EN, combinational from registers. It is glitch-free because both inputs are flops.
- Reset asserted mid-RUN: enc_a and enc_b go to 0 immediately. The resulting jump from 11 to 00 is acceptable and documented.

Decomposition:
- Shared header quad_gen_defs.vh:
  - register offsets (REG_CTRL..REG_REMAIN)
  - CTRL/STATUS bit indices
  - FSM state encodings (ST_IDLE, ST_RUN)
  - the forward phase-order constants, shared with encoder_mmio.
- One sub-module, quad_phase_seq: 2-bit phase register with step and dir inputs, producing enc_a and enc_b.

Test Plan:
- Reset, then read STATUS/POSITION/REMAIN -> all 0x00000000; enc_a=enc_b=0; irq=0.
- PERIOD=4, STEPS=20, CTRL=0x07 (enable, fwd, start) -> {a,b} cycles 01,11,10,00 five times, one edge every 4 clks, first edge 4 clks after the write; DONE=1 after 80 clks; POSITION=0x00000014, REMAIN=0.
- Then STEPS=8, CTRL=0x05 (rev, start) -> sequence 10,11,01,00 twice; POSITION=0x0000000C. Loopback into encoder_mmio shows a matching count.
- PERIOD=10, STEPS=100, start, then ABORT after 35 clks -> exactly 3 edges; BUSY=0, DONE=0, REMAIN=97; outputs frozen. Start with STEPS=0 -> DONE=1 with no edges.
- CLR_POS written on the same cycle as a scheduled edge -> POSITION reads 0. The write to STEPS while BUSY is ignored (STEPS readback is unchanged and the run length is unaffected).
- IRQ_EN=1 with a run to completion -> irq rises with DONE; a new START drops irq. Reset asserted mid-RUN -> all outputs 0 asynchronously, before the next clk edge.
